// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-8 link test: checker state encoding,
// LFSR tap positions, history width and the generator seed.
package prbs_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int HIST_W = 8;
  localparam int TAP_A  = 6;
  localparam int TAP_B  = 7;

  localparam logic [HIST_W-1:0] SEED = 8'h01;

  // Next bit of the b[n] = b[n-7] ^ b[n-8] recurrence; h[0] is the newest bit.
  function automatic logic predict(input logic [HIST_W-1:0] h);
    return h[TAP_A] ^ h[TAP_B];
  endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear on the same edge as
// an increment leaves the counter at 1, so the event that coincides with the
// clear is not lost.
module prbs_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins over hold; increment stops at all-ones.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= W'(inc);
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prbs8_checker.sv
// Serial PRBS-8 checker. Self-synchronises to the b[n] = b[n-7] ^ b[n-8]
// stream in HUNT, then flywheels its own predictor in LOCKED and counts every
// mismatching bit into a saturating error counter.
// Optional build macro: PRBS_CHK_BITCNT_EN adds the bit_count port and a
// 32-bit wrapping counter of accepted bits.
//
// Stream handshake: bit_in is consumed on every rising clk edge where
// bit_valid is high; there is no back-pressure, the checker always accepts.
// With bit_valid low nothing changes state and err_pulse is low.
module prbs8_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_MATCHES = 16,
  parameter int LOSS_WIN     = 64,
  parameter int LOSS_ERRS    = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
`ifdef PRBS_CHK_BITCNT_EN
  output logic [31:0]      bit_count,
`endif
  output state_t           dbg_state
);

  localparam int RUN_W  = $clog2(LOCK_MATCHES + 1);
  localparam int WIN_W  = $clog2(LOSS_WIN);
  localparam int ERR_W  = $clog2(LOSS_ERRS + 1);
  localparam int FILL_W = $clog2(HIST_W + 1);

  state_t              state;
  state_t              state_nx;
  logic [HIST_W-1:0]   hist;
  logic [FILL_W-1:0]   fill;
  logic [RUN_W-1:0]    match_run;
  logic [WIN_W-1:0]    win_cnt;
  logic [ERR_W-1:0]    win_errs;

  logic pred;
  logic filled;
  logic hunt_match;
  logic lock_hit;
  logic bit_err;
  logic loss_hit;
  logic win_wrap;

  // Decode of the current bit against the predictor.
  always_comb begin
    pred       = predict(hist);
    filled     = (fill == FILL_W'(HIST_W));
    // A match on an all-zero history is ignored so a dead line never locks.
    hunt_match = filled && (bit_in == pred) && (hist != '0);
    lock_hit   = (state == HUNT) && bit_valid && hunt_match &&
                 (match_run == RUN_W'(LOCK_MATCHES - 1));
    bit_err    = (state == LOCKED) && bit_valid && (bit_in != pred);
    loss_hit   = bit_err && (win_errs == ERR_W'(LOSS_ERRS - 1));
    win_wrap   = (win_cnt == WIN_W'(LOSS_WIN - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      HUNT:    if (lock_hit) state_nx = LOCKED;
      LOCKED:  if (loss_hit) state_nx = HUNT;
      default: state_nx = HUNT;
    endcase
  end

  // FSM outputs: lock status and state readout straight from the register.
  always_comb begin
    locked    = (state == LOCKED);
    dbg_state = state;
  end

  // History, fill, match-run and loss-window bookkeeping.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hist      <= '0;
      fill      <= '0;
      match_run <= '0;
      win_cnt   <= '0;
      win_errs  <= '0;
    end else if (bit_valid) begin
      // In LOCKED the predictor feeds itself so a flipped bit is seen once.
      hist <= {hist[HIST_W-2:0], (state == LOCKED) ? pred : bit_in};
      case (state)
        HUNT: begin
          win_cnt  <= '0;
          win_errs <= '0;
          if (!filled) begin
            fill <= fill + FILL_W'(1);
          end else if (lock_hit) begin
            match_run <= '0;
          end else if (hunt_match) begin
            match_run <= match_run + RUN_W'(1);
          end else begin
            match_run <= '0;
          end
        end
        LOCKED: begin
          // Loss of lock outranks the window rollover on the same bit.
          if (loss_hit) begin
            fill      <= '0;
            match_run <= '0;
            win_cnt   <= '0;
            win_errs  <= '0;
          end else if (win_wrap) begin
            win_cnt  <= '0;
            win_errs <= '0;
          end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            win_errs <= win_errs + ERR_W'(bit_err);
          end
        end
        default: begin
          fill      <= '0;
          match_run <= '0;
        end
      endcase
    end
  end

  // One-cycle error strobe per errored bit accepted in LOCKED.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= bit_err;
    end
  end

  prbs_sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_err),
    .inc   (bit_err),
    .count (err_count)
  );

`ifdef PRBS_CHK_BITCNT_EN
  // Wrapping total of accepted bits in any state.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bit_count <= '0;
    end else if (bit_valid) begin
      bit_count <= bit_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/prbs8_checker.md
# prbs8_checker

Serial pseudo-random bit-sequence checker for the receive end of the team's PRBS link test. It consumes the bit stream produced by the project's 8-bit LFSR generator (recurrence b[n] = b[n-7] ^ b[n-8]), self-synchronises to it, and declares lock. While locked it flywheels its own predictor and counts every mismatching bit. It sits behind the input pin synchroniser and drives status to the output pins and the debug readout.

## Interface
- LOCK_MATCHES, 16: consecutive correct predictions needed to lock.
- LOSS_WIN, 64: size of the loss-of-lock observation window, in valid bits.
- LOSS_ERRS, 4: errors within one window that force a return to HUNT.
- CNT_W, 16: width of the saturating error counter.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- bit_in  in  1  received serial bit.
- bit_valid  in  1  bit_in is sampled on this edge; when low, no state changes.
- clr_err  in  1  synchronous pulse; clears err_count.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle high for each errored bit accepted in LOCKED.
- err_count  out  CNT_W  saturating error total.
- bit_count  out  32  valid bits accepted since reset; present only with PRBS_CHK_BITCNT_EN.

## Operation
- hist[7:0] holds the bit history; hist[0] is newest. Prediction p = hist[6] ^ hist[7]. Each accepted bit shifts in at hist[0].
- HUNT, the reset state:
  - hist loads received bits.
  - fill counter counts 0..8. No comparisons are made until 8 bits have arrived since entering HUNT.
  - After fill, a bit equal to p increments match_run. A mismatch resets match_run to 0.
  - A match while hist == 0 does not count and resets match_run, so a stuck-at-0 stream never locks.
  - When match_run reaches LOCK_MATCHES, go to LOCKED. win_cnt and win_errs are cleared.
- LOCKED:
  - hist shifts in p, not bit_in (flywheel). Each flipped bit is therefore counted exactly once.
  - bit_in != p raises err_pulse, increments err_count (saturating at 2^CNT_W-1) and increments win_errs.
  - win_cnt counts accepted bits. On the LOSS_WIN-th bit, win_cnt and win_errs clear.
  - If win_errs would reach LOSS_ERRS: go to HUNT on that edge, with fill = 0 and match_run = 0. That error is still counted.
- Errors are counted only in LOCKED. HUNT mismatches never touch err_count.
- clr_err with an error on the same edge gives err_count = 1. clr_err alone gives 0.
- The loss-of-lock check takes priority over the window rollover on the same edge.

## Timing
- Reset values: locked = 0, err_pulse = 0, err_count = 0, bit_count = 0, hist = 0, state HUNT, all counters 0.
- Every output is registered. Each updates at the edge that accepts the causing bit and is visible from the next cycle.
- From HUNT with a clean stream, locked rises at the edge accepting valid bit number 8 + LOCK_MATCHES, which is the 24th bit with defaults.
- err_pulse is high for exactly one cycle per errored bit. It is low on bit_valid = 0 cycles.
- Idle cycles (bit_valid = 0) freeze all state; gaps of any length are allowed.
- Asserting rst_n mid-stream immediately forces all reset values, independent of clk.

## Configuration
- PRBS_CHK_BITCNT_EN defined: the bit_count port and a 32-bit wrapping counter of accepted valid bits, in any state, are compiled in.
- Not defined: the port and the counter are absent; all other behaviour is identical.

## Structure
- The shared package prbs_pkg holds:
  - the state enum {HUNT, LOCKED};
  - the tap constants TAP_A = 6 and TAP_B = 7;
  - the history width 8;
  - the generator seed 8'h01.
- One sub-module, prbs_sat_counter: a CNT_W-bit saturating incrementer with synchronous clear, clear-and-increment giving 1. It implements err_count.

## Test plan
- Reset, then feed the generator stream from seed 8'h01 (1,0,0,0,0,0,0,1,1,...) with valid every cycle. locked rises after the 24th bit; err_count stays 0.
- Same stream with valid on alternate cycles only. locked rises after 24 valid bits (47 cycles); err_pulse stays 0.
- When locked, flip one bit. One err_pulse, err_count = 1, locked stays 1, with no follow-on errors 7 and 8 bits later.
- Flip 4 bits within 64. locked falls on the edge of the 4th error and err_count = 4. locked rises again 24 clean bits later.
- All-zero stream of 200 bits. locked never asserts.
- With CNT_W = 4, inject 20 spaced errors: err_count saturates at 15. Then clr_err on the same edge as an error: err_count = 1. Then assert rst_n mid-stream: all outputs are 0 immediately.
